result_display: RTL and testbench

Sequential back end for the arithmetic result path. Captures the 8-bit unsigned result byte, the add/sub overflow flag and the 2-bit mult/div decimal-point flags on a load request. Converts the byte to three BCD digits with an 8-step shift-and-add-3 (double-dabble) engine and drives three active-low seven-segment digits plus decimal points. A captured overflow makes the whole display blink.

---
 rtl/result_display.sv | 180 ++++++++++++++++++
 tb/tb_result_display.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/result_display.sv
// -----------------------------------------------------------------------------
// result_display
//
// Sequential back end for the arithmetic result path. On a load request (only
// while idle) it captures an 8-bit unsigned result, the add/sub overflow flag
// and the two decimal-point flags. It then runs an 8-step shift-and-add-3
// (double-dabble) conversion to three BCD digits. The digits are driven as
// active-low seven-segment patterns. A displayed overflow makes the whole
// display blink.
//
// Optional feature: define RESULT_DISPLAY_LZB_EN for leading-zero blanking of
// the hundreds and tens digits.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   value  in   [7:0] result byte to display
//   load   in   capture request, honoured only while busy = 0
//   ovf    in   add/sub overflow flag, captured with value
//   dp_in  in   [1:0] decimal-point flags, captured with value
//   busy   out  high while a conversion is in flight
//   done   out  one-cycle pulse, first cycle the new digits are visible
//   hex0   out  [6:0] ones digit, active-low {g,f,e,d,c,b,a}
//   hex1   out  [6:0] tens digit
//   hex2   out  [6:0] hundreds digit
//   dp     out  [2:0] active-low decimal points, dp[i] belongs to hexi
// -----------------------------------------------------------------------------
module result_display #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic       load,
    input  logic       ovf,
    input  logic [1:0] dp_in,
    output logic       busy,
    output logic       done,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [2:0] dp
);

    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t        state_reg, state_next;
    logic [2:0]    cnt_reg;
    logic [19:0]   work_reg;        // {bcd[11:0], bin[7:0]}
    logic          ovf_cap_reg;
    logic [1:0]    dp_cap_reg;
    logic [6:0]    seg0_reg, seg1_reg, seg2_reg;
    logic          ovf_disp_reg;
    logic [1:0]    dp_disp_reg;
    logic          done_reg;
    logic [CW-1:0] blink_cnt_reg;
    logic          phase_reg;

    logic [11:0]   bcd_adj;
    logic [19:0]   work_shift;
    logic [6:0]    seg1_new, seg2_new;
    logic          blank;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h40;
            4'd1:    seg_of = 7'h79;
            4'd2:    seg_of = 7'h24;
            4'd3:    seg_of = 7'h30;
            4'd4:    seg_of = 7'h19;
            4'd5:    seg_of = 7'h12;
            4'd6:    seg_of = 7'h02;
            4'd7:    seg_of = 7'h78;
            4'd8:    seg_of = 7'h00;
            4'd9:    seg_of = 7'h10;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    // Add-3 correction on every BCD nibble that would reach 10 or more after
    // the following doubling.
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
        assign bcd_adj[gi*4 +: 4] = (work_reg[8 + gi*4 +: 4] >= 4'd5)
                                  ? work_reg[8 + gi*4 +: 4] + 4'd3
                                  : work_reg[8 + gi*4 +: 4];
    end

    assign work_shift = {bcd_adj, work_reg[7:0]} << 1;

    // Upper-digit patterns for the commit step.
    always_comb begin
        seg2_new = seg_of(work_reg[19:16]);
        seg1_new = seg_of(work_reg[15:12]);
`ifdef RESULT_DISPLAY_LZB_EN
        if (work_reg[19:16] == 4'd0) begin
            seg2_new = SEG_BLANK;
            if (work_reg[15:12] == 4'd0) begin
                seg1_new = SEG_BLANK;
            end
        end
`endif
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (cnt_reg == 3'd7) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= 3'd0;
            work_reg     <= 20'd0;
            ovf_cap_reg  <= 1'b0;
            dp_cap_reg   <= 2'b00;
            seg0_reg     <= SEG_BLANK;
            seg1_reg     <= SEG_BLANK;
            seg2_reg     <= SEG_BLANK;
            ovf_disp_reg <= 1'b0;
            dp_disp_reg  <= 2'b00;
            done_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == COMMIT);
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        work_reg    <= {12'd0, value};
                        ovf_cap_reg <= ovf;
                        dp_cap_reg  <= dp_in;
                        cnt_reg     <= 3'd0;
                    end
                end
                SHIFT: begin
                    work_reg <= work_shift;
                    cnt_reg  <= cnt_reg + 3'd1;
                end
                COMMIT: begin
                    seg0_reg     <= seg_of(work_reg[11:8]);
                    seg1_reg     <= seg1_new;
                    seg2_reg     <= seg2_new;
                    ovf_disp_reg <= ovf_cap_reg;
                    dp_disp_reg  <= dp_cap_reg;
                end
                default: ;
            endcase
        end
    end

    // Free-running blink timebase, independent of the conversion FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= '0;
            phase_reg     <= ~phase_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end

    assign blank = ovf_disp_reg & phase_reg;
    assign busy  = (state_reg != IDLE);
    assign done  = done_reg;
    assign hex0  = blank ? SEG_BLANK : seg0_reg;
    assign hex1  = blank ? SEG_BLANK : seg1_reg;
    assign hex2  = blank ? SEG_BLANK : seg2_reg;
    assign dp    = blank ? 3'b111 : {1'b1, ~dp_disp_reg};

endmodule

// File: tb/tb_result_display.sv
// -----------------------------------------------------------------------------
// tb_result_display
//
// Directed testbench for result_display with hand-computed expected segment
// patterns. Runs with BLINK_DIV = 4 so the blink behaviour is observable.
// Expectations follow RESULT_DISPLAY_LZB_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_result_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] value;
    logic       load;
    logic       ovf;
    logic [1:0] dp_in;
    logic       busy;
    logic       done;
    logic [6:0] hex0, hex1, hex2;
    logic [2:0] dp;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef RESULT_DISPLAY_LZB_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif

    result_display #(.BLINK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .load  (load),
        .ovf   (ovf),
        .dp_in (dp_in),
        .busy  (busy),
        .done  (done),
        .hex0  (hex0),
        .hex1  (hex1),
        .hex2  (hex2),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got %h exp %h ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got %h exp %h", tag, got, exp);
        end
    endtask

    // Called at a negedge. Issues a one-cycle load and waits (bounded) for done.
    // Returns on the negedge where done is seen, with lat = negedges counted
    // from the load edge and busy_n = number of busy samples before done.
    task automatic run_load(input logic [7:0] v, input logic o, input logic [1:0] d,
                            output int lat, output int busy_n);
        value = v; ovf = o; dp_in = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        lat = 1; busy_n = 0;
        while (!done && lat < 30) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        $display("load value=%0d ovf=%0b dp_in=%b -> lat=%0d busy=%0d hex=%h/%h/%h dp=%b",
                 v, o, d, lat, busy_n, hex2, hex1, hex0, dp);
    endtask

    function automatic logic [23:0] disp();
        return {1'b0, hex2, 1'b0, hex1, hex0, dp};
    endfunction

    function automatic logic [23:0] pat(input logic [6:0] h2, input logic [6:0] h1,
                                        input logic [6:0] h0, input logic [2:0] p);
        return {1'b0, h2, 1'b0, h1, h0, p};
    endfunction

    initial begin
        int lat, bn, blanks, toggles_ok, pattern_ok;
        bit blk [16];

        reset = 1'b1; value = 8'd0; load = 1'b0; ovf = 1'b0; dp_in = 2'b00;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_disp", 32'(disp()), 32'(pat(7'h7F, 7'h7F, 7'h7F, 3'b111)));
        reset = 1'b0;
        @(negedge clk);

        // value 0
        run_load(8'd0, 1'b0, 2'b00, lat, bn);
        check_eq("zero_lat", 32'(lat), 32'd10);
        check_eq("zero_disp", 32'(disp()), 32'(pat(LZ, LZ, 7'h40, 3'b111)));

        // value 255: busy exactly 9 cycles, done exactly 1 cycle
        @(negedge clk);
        run_load(8'd255, 1'b0, 2'b00, lat, bn);
        check_eq("ff_lat", 32'(lat), 32'd10);
        check_eq("ff_busy_n", 32'(bn), 32'd9);
        check_eq("ff_done_busy", 32'(busy), 32'd0);
        check_eq("ff_disp", 32'(disp()), 32'(pat(7'h24, 7'h12, 7'h12, 3'b111)));
        @(negedge clk);
        check_eq("ff_done_1cyc", 32'(done), 32'd0);
        repeat (5) @(negedge clk);
        check_eq("ff_hold", 32'(disp()), 32'(pat(7'h24, 7'h12, 7'h12, 3'b111)));

        // value 159 with overflow: display blinks with half-period 4
        run_load(8'd159, 1'b1, 2'b00, lat, bn);
        check_eq("blink_lat", 32'(lat), 32'd10);
        blanks = 0; toggles_ok = 1; pattern_ok = 1;
        for (int i = 0; i < 16; i++) begin
            if (disp() == pat(7'h7F, 7'h7F, 7'h7F, 3'b111)) begin
                blk[i] = 1'b1; blanks++;
            end else begin
                blk[i] = 1'b0;
                if (disp() != pat(7'h79, 7'h12, 7'h10, 3'b111)) pattern_ok = 0;
            end
            @(negedge clk);
        end
        for (int i = 0; i < 12; i++) begin
            if (blk[i + 4] == blk[i]) toggles_ok = 0;
        end
        check_eq("blink_blanks", 32'(blanks), 32'd8);
        check_eq("blink_period", 32'(toggles_ok), 32'd1);
        check_eq("blink_on_pat", 32'(pattern_ok), 32'd1);

        // value 42, then a load of 7 while busy must be ignored
        value = 8'd42; ovf = 1'b0; dp_in = 2'b00; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        value = 8'd7; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        lat = 3;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        $display("load value=42 with ignored value=7 -> lat=%0d hex=%h/%h/%h", lat, hex2, hex1, hex0);
        check_eq("busy_ign_lat", 32'(lat), 32'd10);
        check_eq("busy_ign_disp", 32'(disp()), 32'(pat(LZ, 7'h19, 7'h24, 3'b111)));

        // load 7 in the done cycle is accepted
        run_load(8'd7, 1'b0, 2'b00, lat, bn);
        check_eq("b2b_lat", 32'(lat), 32'd10);
        check_eq("b2b_disp", 32'(disp()), 32'(pat(LZ, LZ, 7'h78, 3'b111)));

        // dp flags
        @(negedge clk);
        run_load(8'd13, 1'b0, 2'b01, lat, bn);
        check_eq("dp01_disp", 32'(disp()), 32'(pat(LZ, 7'h79, 7'h30, 3'b110)));
        run_load(8'd13, 1'b0, 2'b10, lat, bn);
        check_eq("dp10_disp", 32'(disp()), 32'(pat(LZ, 7'h79, 7'h30, 3'b101)));

        // reset during SHIFT count 4 aborts the conversion
        @(negedge clk);
        value = 8'd100; load = 1'b1;
        @(negedge clk);                 // cycle 1, count 0
        load = 1'b0;
        repeat (4) @(negedge clk);      // cycle 5, count 4
        check_eq("abort_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("reset mid-shift -> busy=%0b done=%0b hex=%h/%h/%h dp=%b", busy, done, hex2, hex1, hex0, dp);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_disp", 32'(disp()), 32'(pat(7'h7F, 7'h7F, 7'h7F, 3'b111)));
        bn = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) bn++;
            @(negedge clk);
        end
        check_eq("abort_no_done", 32'(bn), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
